// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_disp_pkg : shared constants for the scanned hex display (rev 1.0)
// ---------------------------------------------------------------------------
package hex_disp_pkg;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Active-high segment patterns, bit 0 = a .. bit 6 = g
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Digit-index width: $clog2(digits), never below 1
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex7seg_decode : 4-bit nibble to active-high 7-segment pattern (rev 1.0)
// ---------------------------------------------------------------------------
module hex7seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_LUT[nibble];
  end

endmodule
`default_nettype wire

// File: rtl/hex_scan_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_scan_display : time-multiplexed N-digit hex 7-segment driver with
// double-buffered load, leading-zero blanking and decimal points (rev 1.0)
// ---------------------------------------------------------------------------
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int                IDX_W    = idx_width(DIGITS);
  localparam int                PRE_W    = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_IDLE = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_IDLE  = ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    prescaler_q, prescaler_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] display_q, display_d;
  logic [DIGITS-1:0]   display_dp_q, display_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                tick, wrap;
  logic [3:0]          cur_nib;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_raw;
  logic [DIGITS-1:0]   lz;
  logic                zero_run;
  logic                blank;

  // Scan timing and buffering; display only ever changes on the wrap tick
  always_comb begin
    tick         = (prescaler_q == PRE_LAST);
    wrap         = tick && (index_q == IDX_LAST);
    prescaler_d  = tick ? '0 : prescaler_q + PRE_W'(1);
    index_d      = index_q;
    if (tick) begin
      index_d = wrap ? '0 : index_q + IDX_W'(1);
    end
    shadow_d     = load ? data  : shadow_q;
    shadow_dp_d  = load ? dp_in : shadow_dp_q;
    display_d    = wrap ? shadow_q    : display_q;
    display_dp_d = wrap ? shadow_dp_q : display_dp_q;
    frame_done_d = wrap;
  end

  always_comb begin
    cur_nib = display_q[{index_q, 2'b00} +: 4];
  end

  hex7seg_decode u_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // lz[i] is set when every nibble from the top down to digit i is zero
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (display_q[4*i +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
  end

  always_comb begin
    blank   = blank_lz && lz[index_q] && (index_q != '0);
    seg_raw = blank ? SEG_OFF : dec_seg;
    seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d    = ACTIVE_LOW ? ~display_dp_q[index_q] : display_dp_q[index_q];
    an_d    = ACTIVE_LOW ? ~(DIGITS'(1) << index_q) : (DIGITS'(1) << index_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q  <= '0;
      index_q      <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      display_q    <= '0;
      display_dp_q <= '0;
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      an_q         <= AN_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      index_q      <= index_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      display_q    <= display_d;
      display_dp_q <= display_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hex_scan_display : checks a 4-digit active-low and a 1-digit active-high
// instance against a cycle-count based reference model (rev 1.0)
// ---------------------------------------------------------------------------
module tb_hex_scan_display;

  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk;
  logic        reset;
  logic        ld;
  logic        blz;
  logic [15:0] dat;
  logic [3:0]  dpi;

  logic [6:0]  seg4, seg1;
  logic        dp4, dp1;
  logic [3:0]  an4;
  logic        an1;
  logic        fd4, fd1;

  int n_assert = 0;
  int n_fail   = 0;
  int n_fd4    = 0;
  int n_fd1    = 0;

  // Model state: cycle count since reset release plus buffered values
  int          k;
  logic [15:0] m_sh, m_disp;
  logic [3:0]  m_dsh, m_ddisp;
  logic [3:0]  m1_sh, m1_disp;
  logic        m1_dsh, m1_ddisp;

  hex_scan_display #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .data       (dat),
    .dp_in      (dpi),
    .blank_lz   (blz),
    .seg        (seg4),
    .dp         (dp4),
    .an         (an4),
    .frame_done (fd4)
  );

  hex_scan_display #(.DIGITS(1), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .load       (ld),
    .data       (dat[3:0]),
    .dp_in      (dpi[0]),
    .blank_lz   (blz),
    .seg        (seg1),
    .dp         (dp1),
    .an         (an1),
    .frame_done (fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  // Active-high pattern for digit idx of a 4-digit value
  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int idx, input logic bl);
    logic [3:0] n;
    logic       lead;
    n    = v[idx*4 +: 4];
    lead = (idx > 0) && ((v >> (idx * 4)) == 16'd0);
    return (bl && lead) ? 7'h00 : LUT[n];
  endfunction

  task automatic model_clear();
    k = 0;
    m_sh = '0; m_disp = '0; m_dsh = '0; m_ddisp = '0;
    m1_sh = '0; m1_disp = '0; m1_dsh = 1'b0; m1_ddisp = 1'b0;
  endtask

  // One clock: inputs are already set at the preceding falling edge
  task automatic step();
    int         idx;
    logic       wr4, wr1;
    logic [6:0] e_seg4, e_seg1;
    logic       e_dp4, e_dp1;
    logic [3:0] e_an4;
    @(posedge clk);
    idx    = (k / 4) % 4;
    wr4    = ((k % 16) == 15);
    wr1    = ((k % 4) == 3);
    e_seg4 = ~ref_seg(m_disp, idx, blz);
    e_dp4  = ~m_ddisp[idx];
    e_an4  = ~(4'b0001 << idx);
    e_seg1 = LUT[m1_disp];
    e_dp1  = m1_ddisp;
    if (wr4) begin m_disp = m_sh; m_ddisp = m_dsh; end
    if (wr1) begin m1_disp = m1_sh; m1_ddisp = m1_dsh; end
    if (ld) begin
      m_sh = dat; m_dsh = dpi; m1_sh = dat[3:0]; m1_dsh = dpi[0];
    end
    k++;
    #1;
    chk("seg4", seg4, e_seg4);
    chk("dp4",  dp4,  e_dp4);
    chk("an4",  an4,  e_an4);
    chk("fd4",  fd4,  wr4);
    chk("seg1", seg1, e_seg1);
    chk("dp1",  dp1,  e_dp1);
    chk("an1",  an1,  1'b1);
    chk("fd1",  fd1,  wr1);
    if (fd4 === 1'b1) n_fd4++;
    if (fd1 === 1'b1) n_fd1++;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < 16 && (k % 16) != phase; i++) step();
  endtask

  // Reset asserted between clock edges must take effect without a clock
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_seg4", seg4, 7'h7F);
    chk("rst_dp4",  dp4,  1'b1);
    chk("rst_an4",  an4,  4'hF);
    chk("rst_fd4",  fd4,  1'b0);
    chk("rst_seg1", seg1, 7'h00);
    chk("rst_an1",  an1,  1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_seg4", seg4, 7'h7F);
    chk("rst_hold_an4",  an4,  4'hF);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    reset = 1'b0; ld = 1'b0; blz = 1'b0; dat = '0; dpi = '0;
    model_clear();
    do_reset();

    steps(5);

    // Plain digits, each held SCAN_DIV clocks once the frame boundary passes
    ld = 1'b1; dat = 16'h12AF; dpi = 4'b0100;
    steps(40);

    // Mid-scan reset clears everything and restarts the scan
    steps(3);
    do_reset();
    steps(6);

    // Leading-zero blanking, then an all-zero value
    blz = 1'b1;
    ld = 1'b1; dat = 16'h0050; dpi = 4'b1000;
    steps(36);
    ld = 1'b1; dat = 16'h0000; dpi = 4'b0000;
    steps(36);
    blz = 1'b0;
    steps(4);

    // Two loads inside one frame: only the later one is ever displayed
    run_to(1);
    ld = 1'b1; dat = 16'h1111; dpi = 4'b0001;
    steps(4);
    ld = 1'b1; dat = 16'h2222; dpi = 4'b0010;
    steps(36);

    // Load on the wrap-tick cycle shows one frame late
    run_to(15);
    ld = 1'b1; dat = 16'h5A5A; dpi = 4'b1111;
    steps(40);

    // Frame pulse rate over a whole number of frames
    run_to(0);
    n_fd4 = 0; n_fd1 = 0;
    steps(64);
    chk("fd4_count", 16'(n_fd4), 16'd4);
    chk("fd1_count", 16'(n_fd1), 16'd16);

    // Randomized loads, data with varying leading zeros, blank toggling
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 7) == 0);
      dat = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dpi = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blz = ~blz;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
